periph_bus_fabric: RTL

- Parametrised CPU-side bus fabric between `TrashbinCore` and its memory-mapped targets.
- Decodes each CPU access to either the word-addressed data RAM or one of `NUM_PERIPH` peripheral slots.
- Drives a request/ready handshake toward peripherals and returns an ack or error pulse to the CPU.
- Adds behaviour the current fixed two-way split lacks: variable-latency peripherals, unmapped-slot errors and an optional bus timeout.

---
 rtl/trashbin_bus_pkg.sv | 32 +++
 rtl/bus_timeout_counter.sv | 49 ++++
 rtl/periph_bus_fabric.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/trashbin_bus_pkg.sv
// -----------------------------------------------------------------------------
// trashbin_bus_pkg
// Shared definitions for the TrashbinCore CPU-side bus fabric:
//   - bus_state_e  : fabric transaction state
//   - REGION_BIT   : address bit selecting RAM (0) or peripheral space (1)
//   - SLOT_FIELD_W : width of the peripheral slot field above the local address
//   - ERR_RDATA    : read-data pattern returned with an error pulse
//   - slot_mapped(): tells whether a decoded slot index exists
// -----------------------------------------------------------------------------
package trashbin_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RAM_ACC  = 3'd1,
        ST_RAM_DONE = 3'd2,
        ST_PER_WAIT = 3'd3,
        ST_ERR      = 3'd4
    } bus_state_e;

    localparam int REGION_BIT   = 31;
    localparam int SLOT_FIELD_W = 8;

    // Wide enough for any supported DATA_W; users slice the low bits.
    localparam logic [255:0] ERR_RDATA = {256{1'b1}};

    // A slot exists only below the configured slot count.
    function automatic logic slot_mapped(input logic [SLOT_FIELD_W-1:0] slot,
                                         input int unsigned             num_slots);
        return (32'(slot) < num_slots);
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// -----------------------------------------------------------------------------
// bus_timeout_counter
// Counts wait cycles of a peripheral access and flags expiry.
// Ports:
//   clk_i      : clock, rising edge
//   rst_ni     : asynchronous active-low reset
//   clear_i    : synchronous clear of the count (has priority over enable_i)
//   enable_i   : count one wait cycle
//   limit_i    : number of wait cycles allowed (1..65535)
//   expired_o  : high in the wait cycle whose closing edge brings the count
//                to limit_i
// -----------------------------------------------------------------------------
module bus_timeout_counter (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        enable_i,
    input  logic [15:0] limit_i,
    output logic        expired_o
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Next count: clear wins, then saturating increment.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 16'd0;
        end else if (enable_i && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // The cycle being counted now is the limit_i-th one.
    assign expired_o = enable_i && (({1'b0, count_q} + 17'd1) >= {1'b0, limit_i});

endmodule

// File: rtl/periph_bus_fabric.sv
// -----------------------------------------------------------------------------
// periph_bus_fabric
// CPU-side bus fabric for TrashbinCore. Each CPU access is decoded to either
// the word-addressed data RAM (cpu_addr[31]=0) or one of NUM_PERIPH peripheral
// slots (cpu_addr[31]=1, slot in cpu_addr[PERIPH_ADDR_W +: 8]). Unmapped
// slots return an error pulse with all-ones read data.
//
// Optional build macro: BUS_TIMEOUT_EN -- when defined, a peripheral access
// that sees no ready within TIMEOUT_CYCLES wait cycles is aborted with cpu_err.
//
// Ports:
//   CoreClock, CoreReset_n          : clock / async active-low reset
//   cpu_req, cpu_we, cpu_addr,
//   cpu_wdata                       : CPU request (held until ack/err)
//   cpu_rdata, cpu_ack, cpu_err     : CPU response (one-cycle pulses)
//   ram_addr, ram_wdata, ram_we,
//   ram_rdata                       : synchronous RAM, 1-cycle read latency
//   p_sel, p_addr, p_wdata, p_we    : peripheral request (one-hot select)
//   p_rdata, p_ready                : per-slot read data / completion
// -----------------------------------------------------------------------------
module periph_bus_fabric #(
    parameter int DATA_W         = 32,
    parameter int RAM_ADDR_W     = 14,
    parameter int PERIPH_ADDR_W  = 14,
    parameter int NUM_PERIPH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         CoreClock,
    input  logic                         CoreReset_n,
    input  logic                         cpu_req,
    input  logic                         cpu_we,
    input  logic [31:0]                  cpu_addr,
    input  logic [DATA_W-1:0]            cpu_wdata,
    output logic [DATA_W-1:0]            cpu_rdata,
    output logic                         cpu_ack,
    output logic                         cpu_err,
    output logic [RAM_ADDR_W-1:0]        ram_addr,
    output logic [DATA_W-1:0]            ram_wdata,
    output logic                         ram_we,
    input  logic [DATA_W-1:0]            ram_rdata,
    output logic [NUM_PERIPH-1:0]        p_sel,
    output logic [PERIPH_ADDR_W-1:0]     p_addr,
    output logic [DATA_W-1:0]            p_wdata,
    output logic                         p_we,
    input  logic [NUM_PERIPH*DATA_W-1:0] p_rdata,
    input  logic [NUM_PERIPH-1:0]        p_ready
);

    import trashbin_bus_pkg::*;

    bus_state_e              state_q, state_d;
    logic [31:0]             addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic                    we_q, we_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic                    ram_we_q, ram_we_d;
    logic                    p_we_q, p_we_d;
    logic [NUM_PERIPH-1:0]   p_sel_q, p_sel_d;

    logic [SLOT_FIELD_W-1:0] req_slot_s;
    logic [SLOT_FIELD_W-1:0] slot_next_s;
    logic [DATA_W-1:0]       p_rdata_sel_s;
    logic                    ready_sel_s;
    logic                    timeout_s;
    logic                    unused_s;

    assign req_slot_s  = cpu_addr[PERIPH_ADDR_W +: SLOT_FIELD_W];
    // Only the selected slot's ready counts; others are masked by p_sel.
    assign ready_sel_s = |(p_ready & p_sel_q);

    // AND-OR mux of the selected slot's read data (p_sel_q is one-hot).
    always_comb begin
        p_rdata_sel_s = {DATA_W{1'b0}};
        for (int k = 0; k < NUM_PERIPH; k++) begin
            if (p_sel_q[k]) begin
                p_rdata_sel_s = p_rdata_sel_s | p_rdata[k*DATA_W +: DATA_W];
            end else begin
                p_rdata_sel_s = p_rdata_sel_s;
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    // Counter restarts every time the fabric is outside PER_WAIT, so it is
    // zero in the first wait cycle of every peripheral access.
    bus_timeout_counter u_timeout (
        .clk_i     (CoreClock),
        .rst_ni    (CoreReset_n),
        .clear_i   (state_q != ST_PER_WAIT),
        .enable_i  (state_q == ST_PER_WAIT),
        .limit_i   (16'(TIMEOUT_CYCLES)),
        .expired_o (timeout_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and next-output logic of the transaction FSM.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    we_d    = cpu_we;
                    if (!cpu_addr[REGION_BIT]) begin
                        state_d = ST_RAM_ACC;
                    end else if (slot_mapped(req_slot_s, NUM_PERIPH)) begin
                        state_d = ST_PER_WAIT;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RAM_ACC: begin
                state_d = ST_RAM_DONE;
            end
            ST_RAM_DONE: begin
                if (!we_q) begin
                    rdata_d = ram_rdata;
                end else begin
                    rdata_d = rdata_q;
                end
                ack_d   = 1'b1;
                state_d = ST_IDLE;
            end
            ST_PER_WAIT: begin
                // Ready is checked before expiry so it wins a same-edge tie.
                if (ready_sel_s) begin
                    if (!we_q) begin
                        rdata_d = p_rdata_sel_s;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    ack_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (timeout_s) begin
                    rdata_d = ERR_RDATA[DATA_W-1:0];
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PER_WAIT;
                end
            end
            ST_ERR: begin
                rdata_d = ERR_RDATA[DATA_W-1:0];
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobes are derived from the state being entered so that they are
        // registered and line up exactly with RAM_ACC / PER_WAIT.
        ram_we_d    = (state_d == ST_RAM_ACC)  && we_d;
        p_we_d      = (state_d == ST_PER_WAIT) && we_d;
        slot_next_s = addr_d[PERIPH_ADDR_W +: SLOT_FIELD_W];
        for (int k = 0; k < NUM_PERIPH; k++) begin
            p_sel_d[k] = (state_d == ST_PER_WAIT) && (slot_next_s == SLOT_FIELD_W'(k));
        end
    end

    // State, latched request and registered outputs.
    always_ff @(posedge CoreClock or negedge CoreReset_n) begin
        if (!CoreReset_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= 32'd0;
            wdata_q  <= {DATA_W{1'b0}};
            we_q     <= 1'b0;
            rdata_q  <= {DATA_W{1'b0}};
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            ram_we_q <= 1'b0;
            p_we_q   <= 1'b0;
            p_sel_q  <= {NUM_PERIPH{1'b0}};
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            ram_we_q <= ram_we_d;
            p_we_q   <= p_we_d;
            p_sel_q  <= p_sel_d;
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_ack   = ack_q;
    assign cpu_err   = err_q;
    assign ram_addr  = addr_q[RAM_ADDR_W-1:0];
    assign ram_wdata = wdata_q;
    assign ram_we    = ram_we_q;
    assign p_sel     = p_sel_q;
    assign p_addr    = addr_q[PERIPH_ADDR_W-1:0];
    assign p_wdata   = wdata_q;
    assign p_we      = p_we_q;

    // Address bits above the decoded fields and the timeout limit are not
    // consumed in every configuration.
    assign unused_s = ^{addr_q, 16'(TIMEOUT_CYCLES)};

endmodule
